// File: rtl/dcache_rmw_arbiter_if.sv
// Request/response and D-cache signal bundle for dcache_rmw_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface dcache_rmw_arbiter_if;
    logic        p0_req_valid;
    logic        p0_req_rw;
    logic [11:0] p0_req_addr;
    logic [63:0] p0_req_wdata;
    logic [7:0]  p0_req_wstrb;
    logic        p0_req_ready;
    logic        p0_resp_valid;

    logic        p1_req_valid;
    logic        p1_req_rw;
    logic [11:0] p1_req_addr;
    logic [63:0] p1_req_wdata;
    logic [7:0]  p1_req_wstrb;
    logic        p1_req_ready;
    logic        p1_resp_valid;

    logic [63:0] resp_rdata;
    logic        resp_hit;

    logic [11:0] dcache_req_addr;
    logic        dcache_req_valid;
    logic        dcache_req_rw;
    logic [63:0] dcache_data_write;
    logic [63:0] dcache_data_read;
    logic        dcache_ready;
    logic        dcache_hit;

    logic [15:0] perf_miss_cnt;

    modport slave (
        input  p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata, p0_req_wstrb,
        input  p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata, p1_req_wstrb,
        input  dcache_data_read, dcache_ready, dcache_hit,
        output p0_req_ready, p0_resp_valid, p1_req_ready, p1_resp_valid,
        output resp_rdata, resp_hit,
        output dcache_req_addr, dcache_req_valid, dcache_req_rw, dcache_data_write,
        output perf_miss_cnt
    );

    modport master (
        output p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata, p0_req_wstrb,
        output p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata, p1_req_wstrb,
        output dcache_data_read, dcache_ready, dcache_hit,
        input  p0_req_ready, p0_resp_valid, p1_req_ready, p1_resp_valid,
        input  resp_rdata, resp_hit,
        input  dcache_req_addr, dcache_req_valid, dcache_req_rw, dcache_data_write,
        input  perf_miss_cnt
    );
endinterface

// File: rtl/dcache_rmw_arbiter.sv
// Two-port arbiter and read-merge-write sequencer in front of the 64-bit D-cache port.
// Define DCACHE_ARB_RR_EN for round-robin grants; otherwise port 0 has fixed priority.
module dcache_rmw_arbiter (
    input logic                  clk,
    input logic                  rst_n,
    dcache_rmw_arbiter_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;
    logic        rw_q, rw_d;
    logic [11:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [63:0] rd_buf_q, rd_buf_d;
    logic        hit_q, hit_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    logic        any_valid, gnt;
    logic        sel_rw;
    logic [11:0] sel_addr;
    logic [63:0] sel_wdata, merged;
    logic [7:0]  sel_wstrb;
    logic        access_done;

    assign any_valid = bus_io.p0_req_valid | bus_io.p1_req_valid;

`ifdef DCACHE_ARB_RR_EN
    logic last_q, last_d;
    assign gnt = (bus_io.p0_req_valid & bus_io.p1_req_valid) ? ~last_q : ~bus_io.p0_req_valid;
`else
    assign gnt = ~bus_io.p0_req_valid;
`endif

    assign sel_rw    = gnt ? bus_io.p1_req_rw    : bus_io.p0_req_rw;
    assign sel_addr  = gnt ? bus_io.p1_req_addr  : bus_io.p0_req_addr;
    assign sel_wdata = gnt ? bus_io.p1_req_wdata : bus_io.p0_req_wdata;
    assign sel_wstrb = gnt ? bus_io.p1_req_wstrb : bus_io.p0_req_wstrb;

    assign access_done = ((state_q == StRd) || (state_q == StWr)) && bus_io.dcache_ready;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : rd_buf_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_buf_d   = rd_buf_q;
        hit_d      = hit_q;
`ifdef DCACHE_ARB_RR_EN
        last_d     = last_q;
`endif
        bus_io.p0_req_ready      = 1'b0;
        bus_io.p1_req_ready      = 1'b0;
        bus_io.p0_resp_valid     = 1'b0;
        bus_io.p1_resp_valid     = 1'b0;
        bus_io.resp_rdata        = '0;
        bus_io.resp_hit          = 1'b0;
        bus_io.dcache_req_valid  = 1'b0;
        bus_io.dcache_req_rw     = 1'b0;
        bus_io.dcache_req_addr   = '0;
        bus_io.dcache_data_write = '0;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    bus_io.p0_req_ready = ~gnt;
                    bus_io.p1_req_ready = gnt;
                    port_d   = gnt;
                    rw_d     = sel_rw;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    wstrb_d  = sel_wstrb;
                    // Cleared so ops without a read report zero data.
                    rd_buf_d = '0;
                    hit_d    = 1'b1;
`ifdef DCACHE_ARB_RR_EN
                    last_d   = gnt;
`endif
                    if (sel_rw && (sel_wstrb == 8'hFF)) begin
                        state_d = StWr;
                    end else if (sel_rw && (sel_wstrb == 8'h00)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                bus_io.dcache_req_valid = 1'b1;
                bus_io.dcache_req_addr  = addr_q;
                if (bus_io.dcache_ready) begin
                    rd_buf_d = bus_io.dcache_data_read;
                    hit_d    = hit_q & bus_io.dcache_hit;
                    state_d  = rw_q ? StWr : StResp;
                end
            end
            StWr: begin
                bus_io.dcache_req_valid  = 1'b1;
                bus_io.dcache_req_rw     = 1'b1;
                bus_io.dcache_req_addr   = addr_q;
                bus_io.dcache_data_write = merged;
                if (bus_io.dcache_ready) begin
                    hit_d   = hit_q & bus_io.dcache_hit;
                    state_d = StResp;
                end
            end
            StResp: begin
                bus_io.p0_resp_valid = ~port_q;
                bus_io.p1_resp_valid = port_q;
                bus_io.resp_rdata    = rd_buf_q;
                bus_io.resp_hit      = hit_q;
                state_d              = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (access_done && !bus_io.dcache_hit && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    assign bus_io.perf_miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            port_q     <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_buf_q   <= '0;
            hit_q      <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_buf_q   <= rd_buf_d;
            hit_q      <= hit_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

`ifdef DCACHE_ARB_RR_EN
    // Reset as "port 1 last granted" so port 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_rmw_arbiter.sv
// Directed bench for dcache_rmw_arbiter: loads, merged/full/zero-strobe stores,
// arbitration, stalls with misses, counter saturation and mid-op reset.
module tb_dcache_rmw_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rd_cnt;
    int   wr_cnt;
    int   p0_resp_cnt;
    int   p1_resp_cnt;
    logic [63:0] last_wdata;

    dcache_rmw_arbiter_if bus ();

    dcache_rmw_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.dcache_req_valid && bus.dcache_ready) begin
                if (bus.dcache_req_rw) begin
                    wr_cnt     <= wr_cnt + 1;
                    last_wdata <= bus.dcache_data_write;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (bus.p0_resp_valid) p0_resp_cnt <= p0_resp_cnt + 1;
            if (bus.p1_resp_valid) p1_resp_cnt <= p1_resp_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.p0_req_valid = 1'b0;
        bus.p1_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [63:0] exp_gnt;
        checks = 0; errors = 0;
        rd_cnt = 0; wr_cnt = 0; p0_resp_cnt = 0; p1_resp_cnt = 0; last_wdata = '0;
        bus.p0_req_valid = 0; bus.p0_req_rw = 0; bus.p0_req_addr = '0;
        bus.p0_req_wdata = '0; bus.p0_req_wstrb = '0;
        bus.p1_req_valid = 0; bus.p1_req_rw = 0; bus.p1_req_addr = '0;
        bus.p1_req_wdata = '0; bus.p1_req_wstrb = '0;
        bus.dcache_data_read = 64'h1122334455667788;
        bus.dcache_ready = 1'b1;
        bus.dcache_hit   = 1'b1;
        rst_n = 1'b0;

        // Reset state
        tick(); tick(); #1;
        check("rst_dc_valid", bus.dcache_req_valid, 0);
        check("rst_p0_ready", bus.p0_req_ready, 0);
        check("rst_resp", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
        check("rst_perf", bus.perf_miss_cnt, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        tick(); rst_n = 1'b1;

        // Port 0 load, hit on first RD cycle
        tick();
        bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 12'h010;
        #1 check("ld_p0_ready", bus.p0_req_ready, 1);
        check("ld_p1_ready", bus.p1_req_ready, 0);
        tick(); idle_inputs();
        #1 check("ld_rd_valid", bus.dcache_req_valid, 1);
        check("ld_rd_rw", bus.dcache_req_rw, 0);
        check("ld_rd_addr", bus.dcache_req_addr, 12'h010);
        check("ld_no_early_resp", bus.p0_resp_valid, 0);
        tick(); #1;
        check("ld_resp", bus.p0_resp_valid, 1);
        check("ld_rdata", bus.resp_rdata, 64'h1122334455667788);
        check("ld_hit", bus.resp_hit, 1);
        check("ld_reads", rd_cnt, 1);
        tick(); #1;
        check("ld_resp_pulse", bus.p0_resp_valid, 0);

        // Port 1 partial store: read, merge, write
        bus.dcache_data_read = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.p1_req_valid = 1; bus.p1_req_rw = 1; bus.p1_req_addr = 12'h020;
        bus.p1_req_wdata = 64'h0000_0000_00AB_0000; bus.p1_req_wstrb = 8'h04;
        #1 check("ps_p1_ready", bus.p1_req_ready, 1);
        tick(); idle_inputs();
        #1 check("ps_rd_rw", bus.dcache_req_rw, 0);
        check("ps_rd_valid", bus.dcache_req_valid, 1);
        tick(); #1;
        check("ps_wr_rw", bus.dcache_req_rw, 1);
        check("ps_wr_addr", bus.dcache_req_addr, 12'h020);
        check("ps_wr_data", bus.dcache_data_write, 64'hFFFF_FFFF_FFAB_FFFF);
        check("ps_no_early_resp", bus.p1_resp_valid, 0);
        tick(); #1;
        check("ps_resp", bus.p1_resp_valid, 1);
        check("ps_resp_p0", bus.p0_resp_valid, 0);
        check("ps_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ps_reads", rd_cnt, 2);
        check("ps_writes", wr_cnt, 1);
        check("ps_last_wdata", last_wdata, 64'hFFFF_FFFF_FFAB_FFFF);

        // Full-strobe store: no read
        tick();
        bus.p0_req_valid = 1; bus.p0_req_rw = 1; bus.p0_req_addr = 12'h030;
        bus.p0_req_wdata = 64'h0123_4567_89AB_CDEF; bus.p0_req_wstrb = 8'hFF;
        #1 check("fs_ready", bus.p0_req_ready, 1);
        tick(); idle_inputs();
        #1 check("fs_wr_rw", bus.dcache_req_rw, 1);
        check("fs_wr_data", bus.dcache_data_write, 64'h0123_4567_89AB_CDEF);
        tick(); #1;
        check("fs_resp", bus.p0_resp_valid, 1);
        check("fs_rdata", bus.resp_rdata, 0);
        check("fs_reads", rd_cnt, 2);
        check("fs_writes", wr_cnt, 2);

        // Zero-strobe store: no access at all
        tick();
        bus.p1_req_valid = 1; bus.p1_req_rw = 1; bus.p1_req_addr = 12'h031;
        bus.p1_req_wdata = 64'hAAAA_AAAA_AAAA_AAAA; bus.p1_req_wstrb = 8'h00;
        #1 check("zs_ready", bus.p1_req_ready, 1);
        tick(); idle_inputs();
        #1 check("zs_resp", bus.p1_resp_valid, 1);
        check("zs_dc_valid", bus.dcache_req_valid, 0);
        check("zs_hit", bus.resp_hit, 1);
        check("zs_rdata", bus.resp_rdata, 0);
        tick(); #1;
        check("zs_accesses", rd_cnt + wr_cnt, 4);

        // Both ports valid for 4 ops
        bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 12'h100;
        bus.p1_req_valid = 1; bus.p1_req_rw = 0; bus.p1_req_addr = 12'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            w = 0;
            while (!(bus.p0_req_ready | bus.p1_req_ready) && w < 10) begin
                tick(); #1; w++;
            end
            check("arb_timeout", (w < 10), 1);
`ifdef DCACHE_ARB_RR_EN
            exp_gnt = i % 2;
`else
            exp_gnt = 0;
`endif
            check("arb_grant_port", bus.p1_req_ready, exp_gnt);
            check("arb_onehot", bus.p0_req_ready ^ bus.p1_req_ready, 1);
            tick();
        end
        idle_inputs();
        tick(); tick();

        // Stall 5 cycles in RD with a miss
        bus.dcache_ready = 0; bus.dcache_hit = 0;
        bus.dcache_data_read = 64'hDEAD_BEEF_0000_5555;
        bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 12'h3FF;
        #1 check("st_ready", bus.p0_req_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            tick(); idle_inputs();
            #1 check("st_valid_hold", bus.dcache_req_valid, 1);
            check("st_addr_hold", bus.dcache_req_addr, 12'h3FF);
            check("st_rw_hold", bus.dcache_req_rw, 0);
            check("st_no_resp", bus.p0_resp_valid, 0);
        end
        tick(); bus.dcache_ready = 1;
        #1 check("st_valid_c6", bus.dcache_req_valid, 1);
        tick(); #1;
        check("st_resp", bus.p0_resp_valid, 1);
        check("st_rdata", bus.resp_rdata, 64'hDEAD_BEEF_0000_5555);
        check("st_hit", bus.resp_hit, 0);
        check("st_perf", bus.perf_miss_cnt, 1);

        // Saturation of the miss counter
        tick();
        force dut.miss_cnt_q = 16'hFFFE;
        tick();
        release dut.miss_cnt_q;
        #1 check("sat_preload", bus.perf_miss_cnt, 16'hFFFE);
        bus.p0_req_valid = 1; bus.p0_req_rw = 1; bus.p0_req_addr = 12'h040;
        bus.p0_req_wdata = 64'h1111_1111_2222_2222; bus.p0_req_wstrb = 8'h0F;
        #1 check("sat_ready", bus.p0_req_ready, 1);
        tick(); idle_inputs();
        tick(); #1;
        check("sat_wr_data", bus.dcache_data_write, 64'hDEAD_BEEF_2222_2222);
        check("sat_perf_ffff", bus.perf_miss_cnt, 16'hFFFF);
        tick(); #1;
        check("sat_resp", bus.p0_resp_valid, 1);
        check("sat_hold", bus.perf_miss_cnt, 16'hFFFF);
        check("sat_hit", bus.resp_hit, 0);

        // Reset asserted in WR
        bus.dcache_hit = 1;
        tick();
        bus.p1_req_valid = 1; bus.p1_req_rw = 1; bus.p1_req_addr = 12'h050;
        bus.p1_req_wdata = 64'h5555_5555_0000_0000; bus.p1_req_wstrb = 8'hF0;
        #1 check("rw_ready", bus.p1_req_ready, 1);
        tick(); idle_inputs();
        tick(); #1;
        check("rw_in_wr", bus.dcache_req_rw, 1);
        w = p0_resp_cnt + p1_resp_cnt;
        rst_n = 0;
        #1 check("rw_dc_valid", bus.dcache_req_valid, 0);
        check("rw_dc_rw", bus.dcache_req_rw, 0);
        check("rw_dc_addr", bus.dcache_req_addr, 0);
        check("rw_dc_wdata", bus.dcache_data_write, 0);
        check("rw_perf", bus.perf_miss_cnt, 0);
        check("rw_resp", {bus.p0_resp_valid, bus.p1_resp_valid}, 0);
        tick(); tick(); rst_n = 1;
        tick(); tick(); #1;
        check("rw_no_resp", p0_resp_cnt + p1_resp_cnt, w);

        // First request after reset: contested, port 0 expected
        bus.dcache_data_read = 64'h0F0E_0D0C_0B0A_0908;
        bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 12'h060;
        bus.p1_req_valid = 1; bus.p1_req_rw = 0; bus.p1_req_addr = 12'h061;
        #1 check("post_p0_ready", bus.p0_req_ready, 1);
        check("post_p1_ready", bus.p1_req_ready, 0);
        tick(); idle_inputs();
        #1 check("post_rd_addr", bus.dcache_req_addr, 12'h060);
        tick(); #1;
        check("post_resp", bus.p0_resp_valid, 1);
        check("post_rdata", bus.resp_rdata, 64'h0F0E_0D0C_0B0A_0908);
        check("post_hit", bus.resp_hit, 1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_rmw_arbiter.md
# dcache_rmw_arbiter

Sequencer and two-port arbiter in front of the 64-bit D-cache request port. It serves port 0 (MEM stage) and port 1 (secondary master: debug/DMA). Each load becomes one cache read. Sub-doubleword stores become a read–merge–write sequence using byte strobes, so requesters never merge bytes themselves. Full-strobe stores skip the read.

## Interface
- No parameters. Address width is 12 (doubleword index) and data width is 64, both fixed.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req_valid`, `p1_req_valid`  in  1  request valid; held until `pN_req_ready`.
- `p0_req_rw`, `p1_req_rw`  in  1  1 = store, 0 = load.
- `p0_req_addr`, `p1_req_addr`  in  12  doubleword index.
- `p0_req_wdata`, `p1_req_wdata`  in  64  store data, lane-aligned.
- `p0_req_wstrb`, `p1_req_wstrb`  in  8  byte enables; ignored for loads.
- `p0_req_ready`, `p1_req_ready`  out  1  one-cycle accept pulse.
- `p0_resp_valid`, `p1_resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  load data for the port whose `resp_valid` is high; the pre-merge doubleword for stores.
- `resp_hit`  out  1  1 if every cache access of the op hit.
- `dcache_req_addr`  out  12; `dcache_req_valid`  out  1; `dcache_req_rw`  out  1; `dcache_data_write`  out  64.
- `dcache_data_read`  in  64; `dcache_ready`  in  1; `dcache_hit`  in  1.
- `perf_miss_cnt`  out  16  saturating count of cache accesses completed with `dcache_hit`=0.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: if any request is valid, grant one port, pulse its `req_ready`, and latch port id, rw, addr, wdata and wstrb.
  - Load or partial store (wstrb neither 8'hFF nor 8'h00) → RD.
  - Store with wstrb = 8'hFF → WR.
  - Store with wstrb = 8'h00 → RESP; no cache access.
- RD: `dcache_req_valid`=1, `rw`=0, `addr`=latched. On an edge with `dcache_ready`=1, capture `dcache_data_read` into `rd_buf`.
  - Load → RESP.
  - Store → WR.
- WR: `dcache_req_valid`=1, `rw`=1. `dcache_data_write` byte i = wstrb[i] ? wdata byte i : `rd_buf` byte i. For the full-strobe path this is simply wdata. Exit on `dcache_ready`=1 → RESP.
- RESP: pulse the granted port's `resp_valid`; `resp_rdata` = `rd_buf` (0 if no read was done). Next state is IDLE.
- `resp_hit` is the AND of `dcache_hit` sampled at each completing access edge. It is 1 if there was no access.
- `perf_miss_cnt` increments once per completing access with `dcache_hit`=0. It holds at 16'hFFFF.
- Outside RD/WR: `dcache_req_valid`=0, `dcache_req_rw`=0, `dcache_req_addr`=0, `dcache_data_write`=0.
- Requests arriving while not in IDLE get no `ready`. Requesters hold valid and payload stable.

## Timing
- Reset values:
  - All outputs 0, including `perf_miss_cnt`.
  - State IDLE, `rd_buf` 0.
  - Round-robin pointer = "port 1 last granted".
- Reset asserted mid-operation drops `dcache_req_valid` immediately and abandons the op. No `resp_valid` is issued. A partial store may leave no write or a completed write, never a half-merged value.
- Accept at edge 0 (IDLE). With `dcache_ready`=1 on the first RD cycle:
  - Load: `resp_valid` in cycle 2.
  - Partial store: `resp_valid` in cycle 3.
  - Full store: `resp_valid` in cycle 2.
  - Zero-strobe store: `resp_valid` in cycle 1.
- Each cycle of `dcache_ready`=0 in RD/WR adds one cycle. Address, rw and data stay stable throughout.
- Minimum spacing between accepts is 2 cycles (zero-strobe store) because RESP always returns to IDLE.
- `dcache_ready` is ignored outside RD/WR.

## Configuration
- `DCACHE_ARB_RR_EN` defined: round-robin arbitration. When both ports are valid in IDLE, grant the port not granted last. The pointer updates on every grant.
- Not defined: fixed priority, port 0 always wins. Port 1 is granted only when `p0_req_valid`=0. The pointer register is not built.

## Test plan
- Port 0 load, addr 12'h010, cache returns 64'h1122334455667788 with ready=1 and hit=1 on the first RD cycle → `p0_resp_valid` in cycle 2, `resp_rdata`=64'h1122334455667788, `resp_hit`=1, one read on the bus.
- Port 1 store, wstrb 8'h04, wdata 64'h0000_0000_00AB_0000, cache holds 64'hFFFF_FFFF_FFFF_FFFF → exactly one read then one write of 64'hFFFF_FFFF_FFAB_FFFF, `p1_resp_valid` in cycle 3.
- Full-strobe store 8'hFF → no read issued, write data equals wdata, `resp_valid` in cycle 2. Zero-strobe store → no cache access, `resp_valid` in cycle 1.
- Both ports valid continuously for 4 ops → without the macro, 4 port-0 grants. With `DCACHE_ARB_RR_EN`, grants alternate 0,1,0,1.
- `dcache_ready` low for 5 cycles in RD with `dcache_hit`=0 → request signals stable, response 5 cycles late, `resp_hit`=0, `perf_miss_cnt` +1. Preload near 16'hFFFF and verify saturation.
- Assert `rst_n`=0 in WR → `dcache_req_valid` 0 before the next edge, no `resp_valid`, all outputs at reset values, next request accepted normally.
